cpu_timer_bank: RTL and testbench
=================================

CPU_TIMER_BANK -- requirements
Module: cpu_timer_bank

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 65020, first byte address of the register window.
REQ-002 SHALL have parameter NUM_CH, default 4, number of timer channels (legal 1..8).
REQ-003 SHALL have parameter CNT_W, default 16, counter width in bits (legal 8, 16, 24).
REQ-004 SHALL have parameter PRE_W, default 8, prescaler width in bits.
REQ-005 SHALL have port clkCPU, input, 1, clock.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-007 SHALL have port abus, input, 16, CPU address.
REQ-008 SHALL have port wdata, input, 8, CPU write data.
REQ-009 SHALL have port we, input, 1, CPU write strobe, high = write.
REQ-010 SHALL have port rdata, output, 8, registered read data.
REQ-011 SHALL have port rd_hit, output, 1, registered flag: previous-cycle read fell inside the window.
REQ-012 SHALL have port irq, output, 1, OR of (status & irq_en).

Function
REQ-013 SHALL decode a window of 4+8*NUM_CH bytes starting at BASE_ADDR: offset 0 STATUS, 1 IRQ_EN, 2 PRESCALE, 3 reserved, then 8 bytes per channel c at offset 4+8c.
REQ-014 SHALL define per-channel offsets: 0..2 RELOAD bytes (LSB first), 3 CTRL, 4..6 COUNT snapshot bytes (LSB first), 7 reserved; bytes above CNT_W/8 SHALL read 0 and ignore writes.
REQ-015 SHALL define CTRL bits: b0 EN, b1 PERIODIC (1 periodic, 0 one-shot), b2 LOAD (self-clearing, reads 0), b7..b3 read 0.
REQ-016 SHALL return read data for (abus, we=0) on rdata one cycle later, with rd_hit=1 for in-window addresses; out-of-window or we=1 cycles SHALL give rd_hit=0, rdata=0.
REQ-017 SHALL return 0 for reserved offsets with rd_hit=1.
REQ-018 SHALL run a free-running PRE_W down-counter: on reaching 0 assert a one-cycle tick and reload from PRESCALE, giving one tick every PRESCALE+1 clocks.
REQ-019 SHALL make a PRESCALE write take effect only at the next prescaler reload.
REQ-020 SHALL decrement an enabled channel's count by 1 on each tick when count is nonzero.
REQ-021 SHALL, on a tick with count==0 and EN=1, set STATUS[c]; periodic: load count from RELOAD; one-shot: clear EN, count stays 0.
REQ-022 SHALL load count from RELOAD when CTRL is written with EN rising 0->1 or with LOAD=1.
REQ-023 SHALL make RELOAD writes not alter a running count until the next load event.
REQ-024 SHALL, with RELOAD=0 and periodic, set STATUS every tick.
REQ-025 SHALL capture bytes 1..2 of count into a snapshot register when count byte 0 is read, so that bytes 1..2 read that snapshot.
REQ-026 SHALL clear STATUS bits written as 1 (write-1-to-clear); a same-cycle set event SHALL win over clear.
REQ-027 SHALL ignore a tick on a channel in the same cycle as a CTRL load or RELOAD-driven load, with the load winning.
REQ-028 SHALL drive irq combinationally from registered STATUS and IRQ_EN only (no glitch from abus).
REQ-029 SHALL ignore STATUS/IRQ_EN bits at or above NUM_CH (read 0).

Reset
REQ-030 SHALL on reset clear STATUS, IRQ_EN, PRESCALE, prescaler counter, all RELOAD, CTRL, count, snapshot, rdata, rd_hit; irq=0.
REQ-031 SHALL abort any counting in progress on reset; no status set on the release cycle.
REQ-032 SHALL after reset release tick every clock (PRESCALE=0).

Verification
REQ-033 SHALL cover: PRESCALE=0, ch0 RELOAD=3, CTRL=0x03, IRQ_EN=0x01 -> STATUS[0] and irq rise 4 clocks after count reaches 3 then every 4 clocks.
REQ-034 SHALL cover: ch1 one-shot RELOAD=2, CTRL=0x01 -> STATUS[1] set once, CTRL reads 0x00, count 0, no further sets.
REQ-035 SHALL cover: PRESCALE=9, ch0 periodic RELOAD=0 -> STATUS[0] set every 10 clocks.
REQ-036 SHALL cover: count=0x0100 decrementing, read count byte 0 (0x00) then byte 1 after a tick -> byte 1 reads 0x01 (snapshot), not 0x00.
REQ-037 SHALL cover: write STATUS=0x01 in same cycle as ch0 expiry -> STATUS[0] remains 1; a later W1C clears it and irq falls.
REQ-038 SHALL cover: assert reset mid-count with irq=1 -> all outputs 0 immediately; read of BASE_ADDR after release gives rdata=0x00, rd_hit=1.

Source files
------------

// File: rtl/cpu_timer_bank.sv
// CPU-mapped bank of prescaled down-counting timers with a shared status/irq block.
// Byte-wide register window with one-cycle registered read data.
module cpu_timer_bank #(
    parameter int BASE_ADDR = 65020,
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int PRE_W     = 8
) (
    input  logic        clkCPU,
    input  logic        reset,
    input  logic [15:0] abus,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic [7:0]  rdata,
    output logic        rd_hit,
    output logic        irq
);

    localparam int          NB      = CNT_W / 8;
    localparam int          WIN     = 4 + 8 * NUM_CH;
    localparam logic [16:0] WIN_LO  = 17'(BASE_ADDR);
    localparam logic [16:0] WIN_HI  = 17'(BASE_ADDR + WIN);
    localparam logic [6:0]  BASE_LO = 7'(BASE_ADDR);

    function automatic logic [7:0] get_byte(input logic [CNT_W-1:0] v, input logic [2:0] b);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < NB; i++) begin
            if (b == 3'(i)) r = v[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] put_byte(input logic [CNT_W-1:0] v,
                                                  input logic [2:0] b,
                                                  input logic [7:0] d);
        logic [CNT_W-1:0] r;
        r = v;
        for (int i = 0; i < NB; i++) begin
            if (b == 3'(i)) r[8*i +: 8] = d;
        end
        return r;
    endfunction

    logic              in_win;
    logic              rd_req;
    logic              wr_req;
    logic              glob_sel;
    logic [6:0]        off;
    logic [6:0]        ch_off;
    logic [2:0]        ch_sel;
    logic [2:0]        byte_sel;
    logic [NUM_CH-1:0] ch_hit;

    logic [NUM_CH-1:0] status_q, status_d;
    logic [NUM_CH-1:0] irq_en_q;
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] per_q, per_d;
    logic [NUM_CH-1:0] set_evt;
    logic [PRE_W-1:0]  prescale_q;
    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;

    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [CNT_W-1:0]  count_d  [NUM_CH];
    logic [CNT_W-1:0]  reload_q [NUM_CH];
    logic [CNT_W-1:0]  reload_d [NUM_CH];
    logic [CNT_W-1:0]  snap_q   [NUM_CH];
    logic [CNT_W-1:0]  snap_d   [NUM_CH];

    logic [7:0]        rd_val_p0;

    // Offset arithmetic only needs the low address bits once the full compare says we are inside.
    assign in_win   = ({1'b0, abus} >= WIN_LO) && ({1'b0, abus} < WIN_HI);
    assign off      = abus[6:0] - BASE_LO;
    assign ch_off   = off - 7'd4;
    assign ch_sel   = 3'(ch_off >> 3);
    assign byte_sel = ch_off[2:0];
    assign glob_sel = off < 7'd4;
    assign rd_req   = in_win && !we;
    assign wr_req   = in_win && we;
    assign tick     = (pre_cnt == '0);

    always_comb begin
        ch_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_hit[c] = in_win && !glob_sel && (ch_sel == 3'(c));
        end
    end

    // A CTRL write owns the channel for that cycle, so a coincident tick is dropped.
    always_comb begin
        set_evt = '0;
        en_d    = en_q;
        per_d   = per_q;
        for (int c = 0; c < NUM_CH; c++) begin
            count_d[c]  = count_q[c];
            reload_d[c] = reload_q[c];
            snap_d[c]   = snap_q[c];
            if (rd_req && ch_hit[c] && byte_sel == 3'd4) snap_d[c] = count_q[c];
            if (wr_req && ch_hit[c] && byte_sel < 3'd3)
                reload_d[c] = put_byte(reload_q[c], byte_sel, wdata);
            if (wr_req && ch_hit[c] && byte_sel == 3'd3) begin
                en_d[c]  = wdata[0];
                per_d[c] = wdata[1];
                if ((wdata[0] && !en_q[c]) || wdata[2]) count_d[c] = reload_q[c];
            end else if (tick && en_q[c]) begin
                if (count_q[c] != '0) begin
                    count_d[c] = count_q[c] - CNT_W'(1);
                end else begin
                    set_evt[c] = 1'b1;
                    if (per_q[c]) count_d[c] = reload_q[c];
                    else          en_d[c]    = 1'b0;
                end
            end
        end
        status_d = status_q;
        if (wr_req && glob_sel && off == 7'd0) status_d = status_q & ~wdata[NUM_CH-1:0];
        status_d = status_d | set_evt;
    end

    always_comb begin
        rd_val_p0 = 8'd0;
        if (glob_sel) begin
            case (off[1:0])
                2'd0:    rd_val_p0 = 8'(status_q);
                2'd1:    rd_val_p0 = 8'(irq_en_q);
                2'd2:    rd_val_p0 = 8'(prescale_q);
                default: rd_val_p0 = 8'd0;
            endcase
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_hit[c]) begin
                    case (byte_sel)
                        3'd0, 3'd1, 3'd2: rd_val_p0 = get_byte(reload_q[c], byte_sel);
                        3'd3:             rd_val_p0 = {6'd0, per_q[c], en_q[c]};
                        3'd4:             rd_val_p0 = get_byte(count_q[c], 3'd0);
                        3'd5:             rd_val_p0 = get_byte(snap_q[c], 3'd1);
                        3'd6:             rd_val_p0 = get_byte(snap_q[c], 3'd2);
                        default:          rd_val_p0 = 8'd0;
                    endcase
                end
            end
        end
    end

    // Stage p0 -> p1: register state and the read response.
    always_ff @(posedge clkCPU or posedge reset) begin
        if (reset) begin
            status_q   <= '0;
            irq_en_q   <= '0;
            en_q       <= '0;
            per_q      <= '0;
            prescale_q <= '0;
            pre_cnt    <= '0;
            rdata      <= 8'd0;
            rd_hit     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                count_q[c]  <= '0;
                reload_q[c] <= '0;
                snap_q[c]   <= '0;
            end
        end else begin
            status_q <= status_d;
            en_q     <= en_d;
            per_q    <= per_d;
            if (wr_req && glob_sel && off == 7'd1) irq_en_q   <= wdata[NUM_CH-1:0];
            if (wr_req && glob_sel && off == 7'd2) prescale_q <= PRE_W'(wdata);
            pre_cnt <= tick ? prescale_q : pre_cnt - PRE_W'(1);
            rdata   <= rd_req ? rd_val_p0 : 8'd0;
            rd_hit  <= rd_req;
            for (int c = 0; c < NUM_CH; c++) begin
                count_q[c]  <= count_d[c];
                reload_q[c] <= reload_d[c];
                snap_q[c]   <= snap_d[c];
            end
        end
    end

    assign irq = |(status_q & irq_en_q);

endmodule

// File: tb/tb_cpu_timer_bank.sv
// Directed bench for cpu_timer_bank: an integer-level model of the register
// window and timers is compared every clock, plus hand-computed literal checks.
module tb_cpu_timer_bank;

    localparam int BASE = 65020;
    localparam int NCH  = 4;
    localparam int WIN  = 4 + 8 * NCH;
    localparam int CH0  = BASE + 4;
    localparam int CH1  = BASE + 12;
    localparam int CH2  = BASE + 20;
    localparam int CH3  = BASE + 28;

    logic        clkCPU = 1'b0;
    logic        reset;
    logic [15:0] abus;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  rdata;
    logic        rd_hit;
    logic        irq;

    cpu_timer_bank #(
        .BASE_ADDR(BASE),
        .NUM_CH   (NCH),
        .CNT_W    (16),
        .PRE_W    (8)
    ) dut (
        .clkCPU(clkCPU),
        .reset (reset),
        .abus  (abus),
        .wdata (wdata),
        .we    (we),
        .rdata (rdata),
        .rd_hit(rd_hit),
        .irq   (irq)
    );

    always #5 clkCPU = ~clkCPU;

    int total = 0;
    int bad   = 0;

    int m_status, m_irqen, m_pre, m_precnt, m_rdata;
    int m_reload [NCH];
    int m_cnt    [NCH];
    int m_snap   [NCH];
    int m_en     [NCH];
    int m_per    [NCH];
    int m_rdhit;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_status = 0; m_irqen = 0; m_pre = 0; m_precnt = 0;
        m_rdata = 0; m_rdhit = 0;
        for (int c = 0; c < NCH; c++) begin
            m_reload[c] = 0; m_cnt[c] = 0; m_snap[c] = 0; m_en[c] = 0; m_per[c] = 0;
        end
    endtask

    // What one clock edge does to the register file, given the bus inputs.
    task automatic model_step(input int a, input int w, input int d);
        int off, c, b, rv, setm, oldpre, o;
        int inw, tick;
        inw  = (a >= BASE) && (a < BASE + WIN);
        off  = a - BASE;
        tick = (m_precnt == 0);
        rv   = 0;
        if (inw && !w) begin
            if (off < 4) begin
                case (off)
                    0: rv = m_status;
                    1: rv = m_irqen;
                    2: rv = m_pre;
                    default: rv = 0;
                endcase
            end else begin
                c = (off - 4) / 8;
                b = (off - 4) % 8;
                case (b)
                    0, 1, 2: rv = (m_reload[c] >> (8 * b)) & 255;
                    3:       rv = m_en[c] + 2 * m_per[c];
                    4:       rv = m_cnt[c] & 255;
                    5:       rv = (m_snap[c] >> 8) & 255;
                    6:       rv = (m_snap[c] >> 16) & 255;
                    default: rv = 0;
                endcase
            end
        end
        setm = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            o = off - (4 + 8 * ch);
            if (inw && !w && o == 4) m_snap[ch] = m_cnt[ch];
            if (inw && w && o == 0) m_reload[ch] = (m_reload[ch] & 'hFF00) | d;
            if (inw && w && o == 1) m_reload[ch] = (m_reload[ch] & 'h00FF) | (d << 8);
            if (inw && w && o == 3) begin
                if ((((d & 1) != 0) && m_en[ch] == 0) || ((d & 4) != 0)) m_cnt[ch] = m_reload[ch];
                m_en[ch]  = d & 1;
                m_per[ch] = (d >> 1) & 1;
            end else if (tick && m_en[ch] != 0) begin
                if (m_cnt[ch] > 0) begin
                    m_cnt[ch] = m_cnt[ch] - 1;
                end else begin
                    setm = setm | (1 << ch);
                    if (m_per[ch] != 0) m_cnt[ch] = m_reload[ch];
                    else                m_en[ch]  = 0;
                end
            end
        end
        if (inw && w && off == 0) m_status = m_status & ~d;
        m_status = (m_status | setm) & 15;
        if (inw && w && off == 1) m_irqen = d & 15;
        oldpre = m_pre;
        if (inw && w && off == 2) m_pre = d;
        m_precnt = tick ? oldpre : m_precnt - 1;
        m_rdata  = rv;
        m_rdhit  = inw && !w;
    endtask

    task automatic cyc(input int a, input int w, input int d);
        abus  = 16'(a);
        we    = (w != 0);
        wdata = 8'(d);
        model_step(a, w, d);
        @(posedge clkCPU);
        #1;
        chk("rdata", int'(rdata), m_rdata);
        chk("rd_hit", int'(rd_hit), m_rdhit);
        chk("irq", int'(irq), ((m_status & m_irqen) != 0) ? 1 : 0);
    endtask

    initial begin
        reset = 1'b1; abus = 16'd0; we = 1'b0; wdata = 8'd0;
        model_reset();
        #12;
        chk("rst_rdata", int'(rdata), 0);
        chk("rst_rdhit", int'(rd_hit), 0);
        chk("rst_irq", int'(irq), 0);
        reset = 1'b0;

        // Window decode and masking of unimplemented bits
        cyc(BASE + 1, 1, 'hFF);
        chk("wr_no_hit", int'(rd_hit), 0);
        cyc(BASE + 1, 0, 0);
        chk("irqen_mask", int'(rdata), 'h0F);
        cyc(BASE - 1, 0, 0);
        chk("below_win", int'(rd_hit), 0);
        cyc(BASE + WIN, 0, 0);
        chk("above_win", int'(rd_hit), 0);
        cyc(BASE + 3, 0, 0);
        chk("rsvd_data", int'(rdata), 0);
        chk("rsvd_hit", int'(rd_hit), 1);
        cyc(BASE + 1, 1, 1);

        // Periodic ch0, reload 3, tick every clock
        cyc(CH0, 1, 3);
        cyc(CH0 + 1, 1, 0);
        cyc(CH0 + 2, 1, 'h55);
        cyc(CH0 + 2, 0, 0);
        chk("rel_b2_ign", int'(rdata), 0);
        cyc(CH0, 0, 0);
        chk("rel_b0", int'(rdata), 3);
        cyc(CH0 + 3, 1, 3);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 0);
            chk("r33_rise", int'(irq), (i == 4) ? 1 : 0);
        end
        for (int i = 5; i <= 8; i++) begin
            if (i == 5) cyc(BASE, 1, 1);
            else        cyc(0, 0, 0);
            chk("r33_period", int'(irq), (i == 8) ? 1 : 0);
        end
        cyc(CH0 + 3, 1, 0);
        cyc(BASE, 1, 1);
        chk("r33_off", int'(irq), 0);

        // One-shot ch1, reload 2
        cyc(CH1, 1, 2);
        cyc(CH1 + 3, 1, 1);
        repeat (6) cyc(0, 0, 0);
        cyc(CH1 + 3, 0, 0);
        chk("r34_ctrl", int'(rdata), 0);
        cyc(CH1 + 4, 0, 0);
        chk("r34_cnt", int'(rdata), 0);
        cyc(BASE, 0, 0);
        chk("r34_stat", int'(rdata), 2);
        cyc(BASE, 1, 2);
        repeat (5) cyc(0, 0, 0);
        cyc(BASE, 0, 0);
        chk("r34_once", int'(rdata), 0);

        // PRESCALE=9, ch0 periodic reload 0; W1C every cycle, set must win
        cyc(BASE + 2, 1, 9);
        cyc(CH0, 1, 0);
        cyc(CH0 + 1, 1, 0);
        cyc(CH0 + 3, 1, 3);
        for (int j = 0; j < 40; j++) begin
            cyc(BASE, 1, 1);
            chk("r35_pulse", int'(irq), (j % 10 == 7) ? 1 : 0);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 0);
            chk("r37_hold", int'(irq), (k == 8) ? 1 : 0);
        end
        cyc(BASE, 1, 1);
        chk("r37_fall", int'(irq), 0);
        cyc(CH0 + 3, 1, 0);
        cyc(BASE, 1, 1);

        // Count snapshot: ch2 one-shot from 0x0100 with slow prescaler
        cyc(BASE + 2, 1, 255);
        repeat (12) cyc(0, 0, 0);
        cyc(CH2, 1, 0);
        cyc(CH2 + 1, 1, 1);
        cyc(CH2 + 3, 1, 1);
        cyc(CH2 + 4, 0, 0);
        chk("r36_b0", int'(rdata), 'h00);
        repeat (260) cyc(0, 0, 0);
        cyc(CH2 + 5, 0, 0);
        chk("r36_snap", int'(rdata), 'h01);
        cyc(CH2 + 4, 0, 0);
        chk("r36_live", int'(rdata), 'hFF);
        cyc(CH2 + 5, 0, 0);
        chk("r36_resnap", int'(rdata), 'h00);
        cyc(CH2 + 6, 1, 'hAA);
        cyc(CH2 + 6, 0, 0);
        chk("cnt_b2", int'(rdata), 0);
        cyc(CH2 + 7, 0, 0);
        chk("ch_rsvd", int'(rdata), 0);
        chk("ch_rsvd_hit", int'(rd_hit), 1);
        cyc(CH2 + 2, 1, 'h77);
        cyc(CH2 + 2, 0, 0);
        chk("rel_b2_ch2", int'(rdata), 0);
        cyc(CH2 + 3, 1, 0);
        cyc(BASE, 1, 15);

        // Reset in the middle of counting with irq high
        cyc(BASE + 2, 1, 0);
        repeat (260) cyc(0, 0, 0);
        cyc(BASE + 1, 1, 15);
        cyc(CH3, 1, 5);
        cyc(CH3 + 3, 1, 3);
        repeat (8) cyc(0, 0, 0);
        cyc(BASE, 0, 0);
        chk("r38_pre_stat", int'(rdata), 'h08);
        chk("r38_pre_irq", int'(irq), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("r38_rdata0", int'(rdata), 0);
        chk("r38_rdhit0", int'(rd_hit), 0);
        chk("r38_irq0", int'(irq), 0);
        @(posedge clkCPU);
        #1;
        reset = 1'b0;
        model_reset();
        cyc(BASE, 0, 0);
        chk("r38_rd", int'(rdata), 0);
        chk("r38_hit", int'(rd_hit), 1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0);
            chk("r38_quiet", int'(irq), 0);
        end
        cyc(CH3 + 3, 0, 0);
        chk("r38_ctrl", int'(rdata), 0);
        cyc(CH3, 0, 0);
        chk("r38_rel", int'(rdata), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
